// File: rtl/apb_to_ahbl.sv
// APB3 completer to AHB-Lite manager bridge: each APB transfer becomes one
// NONSEQ SINGLE word transfer, with pready held low until the AHB data phase ends.
`timescale 1ns/1ps
module apb_to_ahbl #(
    parameter int unsigned          W_PADDR    = 16,
    parameter int unsigned          W_HADDR    = 32,
    parameter int unsigned          W_DATA     = 32,
    parameter logic [W_HADDR-1:0]   HADDR_BASE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                apbs_psel,
    input  logic                apbs_penable,
    input  logic                apbs_pwrite,
    input  logic [W_PADDR-1:0]  apbs_paddr,
    input  logic [W_DATA-1:0]   apbs_pwdata,
    output logic                apbs_pready,
    output logic [W_DATA-1:0]   apbs_prdata,
    output logic                apbs_pslverr,
    output logic [W_HADDR-1:0]  ahblm_haddr,
    output logic                ahblm_hwrite,
    output logic [1:0]          ahblm_htrans,
    output logic [2:0]          ahblm_hsize,
    output logic [2:0]          ahblm_hburst,
    output logic [3:0]          ahblm_hprot,
    output logic                ahblm_hmastlock,
    output logic [W_DATA-1:0]   ahblm_hwdata,
    input  logic                ahblm_hready,
    input  logic                ahblm_hresp,
    input  logic [W_DATA-1:0]   ahblm_hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APHASE,
        S_DPHASE,
        S_RESP
    } state_t;

    state_t              state_q,  state_d;
    logic [W_HADDR-1:0]  haddr_q,  haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [W_DATA-1:0]   hwdata_q, hwdata_d;
    logic [W_DATA-1:0]   prdata_q, prdata_d;
    logic                err_q,    err_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath updates; only a setup phase starts a transfer
    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        prdata_d = prdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (apbs_psel && !apbs_penable) begin
                    haddr_d  = HADDR_BASE | W_HADDR'(apbs_paddr);
                    hwrite_d = apbs_pwrite;
                    hwdata_d = apbs_pwdata;
                    state_d  = S_APHASE;
                end
            end
            S_APHASE: begin
                if (ahblm_hready) begin
                    state_d = S_DPHASE;
                end
            end
            S_DPHASE: begin
                if (ahblm_hready) begin
                    if (!hwrite_q) begin
                        prdata_d = ahblm_hresp ? '0 : ahblm_hrdata;
                    end
                    err_d   = ahblm_hresp;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from the state register
    assign ahblm_htrans    = (state_q == S_APHASE) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_hwdata    = hwdata_q;
    assign ahblm_hsize     = 3'b010;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

    assign apbs_pready  = (state_q == S_RESP);
    assign apbs_pslverr = (state_q == S_RESP) && err_q;
    assign apbs_prdata  = prdata_q;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Randomised and directed bench for apb_to_ahbl with a latency/data model
// derived from the bridge's transfer rules.
`timescale 1ns/1ps
module tb_apb_to_ahbl;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_prdata = 32'h0;

    typedef struct {
        int          cyc;
        int          nonseq;
        logic [31:0] haddr;
        logic        hwrite;
        logic [31:0] prdata;
        logic        pslverr;
        bit          addr_bad;
        bit          dph_bad;
        bit          side_bad;
    } obs_t;

    always #5 clk = ~clk;

    apb_to_ahbl #(
        .W_PADDR(16), .W_HADDR(32), .W_DATA(32), .HADDR_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata),
        .apbs_pready(pready), .apbs_prdata(prdata), .apbs_pslverr(pslverr),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
    );

    // Cycles from setup to the pready cycle: 4-cycle transfer, +1 per wait, +1 for error's first cycle
    function automatic int model_latency(input int aw, input int dw, input bit err);
        return 3 + aw + dw + (err ? 1 : 0);
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        end
    endtask

    // Drive one APB transfer plus a scheduled AHB slave, and record what the bridge did
    task automatic run_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                            input int aw, input int dw, input bit err, input logic [31:0] rdata,
                            input int drop_at, output obs_t o);
        int k;
        int last_d;
        k = 0;
        last_d = 2 + aw + dw + (err ? 1 : 0);
        o.cyc = -1; o.nonseq = 0; o.haddr = '0; o.hwrite = 1'b0; o.prdata = '0;
        o.pslverr = 1'b0; o.addr_bad = 0; o.dph_bad = 0; o.side_bad = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        if (pready !== 1'b0 || htrans !== 2'b00) o.side_bad = 1;
        while (o.cyc < 0 && k < last_d + 10) begin
            @(posedge clk); #1;
            k++;
            if (htrans === 2'b10) begin
                if (o.nonseq == 0) begin
                    o.haddr = haddr; o.hwrite = hwrite;
                end else if (haddr !== o.haddr || hwrite !== o.hwrite) begin
                    o.addr_bad = 1;
                end
                o.nonseq++;
                if (hsize !== 3'b010 || hburst !== 3'b000 || hprot !== 4'b0011 || hmastlock !== 1'b0)
                    o.addr_bad = 1;
            end else if (htrans !== 2'b00) begin
                o.addr_bad = 1;
            end
            if (k >= aw + 2 && k <= last_d)
                if (htrans !== 2'b00 || (wr && hwdata !== wdata)) o.dph_bad = 1;
            if (pready === 1'b1) begin
                o.cyc = k; o.prdata = prdata; o.pslverr = pslverr;
            end else if (pready !== 1'b0 || pslverr !== 1'b0) begin
                o.side_bad = 1;
            end
            penable = 1'b1;
            if (drop_at > 0 && k >= drop_at) begin
                psel = 1'b0; penable = 1'b0;
            end
            hrdata = $urandom;
            if (k <= aw) begin
                hready = 1'b0; hresp = 1'b0;
            end else if (k == aw + 1) begin
                hready = 1'b1; hresp = 1'b0;
            end else if (k < aw + 2 + dw) begin
                hready = 1'b0; hresp = 1'b0;
            end else if (err && k == last_d - 1) begin
                hready = 1'b0; hresp = 1'b1;
            end else if (k == last_d) begin
                hready = 1'b1; hresp = err; hrdata = rdata;
            end else begin
                hready = 1'b1; hresp = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (htrans !== 2'b00 || pready !== 1'b0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: htrans=%b pready=%b pslverr=%b, want 00/0/0", htrans, pready, pslverr);
        end
        checks++;
        if (haddr !== 32'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 || prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: haddr=%h hwrite=%b hwdata=%h prdata=%h, want all zero",
                     haddr, hwrite, hwdata, prdata);
        end
        checks++;
        if (hsize !== 3'b010 || hburst !== 3'b000 || hprot !== 4'b0011 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: hsize=%b hburst=%b hprot=%b hmastlock=%b, want 010/000/0011/0",
                     hsize, hburst, hprot, hmastlock);
        end
        rst_n = 1'b1;
        model_prdata = 32'h0;
    endtask

    task automatic test_write();
        obs_t o;
        run_xfer(1'b1, 16'h0040, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 0, o);
        checks++;
        if (o.cyc !== 3 || o.pslverr !== 1'b0) begin
            errors++; $display("FAIL write_timing: pready cycle=%0d pslverr=%b, want 3/0", o.cyc, o.pslverr);
        end
        checks++;
        if (o.nonseq !== 1 || o.haddr !== 32'h4000_0040 || o.hwrite !== 1'b1 || o.addr_bad) begin
            errors++;
            $display("FAIL write_aphase: nonseq=%0d haddr=%h hwrite=%b bad=%0d, want 1/40000040/1/0",
                     o.nonseq, o.haddr, o.hwrite, o.addr_bad);
        end
        checks++;
        if (o.dph_bad || o.side_bad || o.prdata !== model_prdata) begin
            errors++;
            $display("FAIL write_dphase: dph_bad=%0d side_bad=%0d prdata=%h, want 0/0/%h",
                     o.dph_bad, o.side_bad, o.prdata, model_prdata);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        idle_cycles(2);
        run_xfer(1'b0, 16'h0008, 32'h0, 0, 2, 1'b0, 32'h1234_5678, 0, o);
        model_prdata = 32'h1234_5678;
        checks++;
        if (o.cyc !== model_latency(0, 2, 1'b0)) begin
            errors++; $display("FAIL read_wait_cycle: pready cycle=%0d, want 5", o.cyc);
        end
        checks++;
        if (o.prdata !== model_prdata || o.pslverr !== 1'b0 || o.haddr !== 32'h4000_0008) begin
            errors++;
            $display("FAIL read_wait_data: prdata=%h pslverr=%b haddr=%h, want %h/0/40000008",
                     o.prdata, o.pslverr, o.haddr, model_prdata);
        end
    endtask

    task automatic test_error();
        obs_t o;
        run_xfer(1'b0, 16'h0010, 32'h0, 0, 0, 1'b1, 32'hCAFE_F00D, 0, o);
        model_prdata = 32'h0;
        checks++;
        if (o.cyc !== model_latency(0, 0, 1'b1) || o.pslverr !== 1'b1 || o.prdata !== 32'h0) begin
            errors++;
            $display("FAIL error_resp: cycle=%0d pslverr=%b prdata=%h, want 4/1/00000000",
                     o.cyc, o.pslverr, o.prdata);
        end
        checks++;
        if (o.dph_bad || o.nonseq !== 1) begin
            errors++; $display("FAIL error_htrans: dph_bad=%0d nonseq=%0d, want 0/1", o.dph_bad, o.nonseq);
        end
    endtask

    task automatic test_aphase_hold();
        obs_t o;
        idle_cycles(1);
        run_xfer(1'b1, 16'h1230, 32'h0BAD_F00D, 3, 0, 1'b0, 32'h0, 0, o);
        checks++;
        if (o.nonseq !== 4 || o.addr_bad || o.haddr !== 32'h4000_1230) begin
            errors++;
            $display("FAIL aphase_hold: nonseq=%0d addr_bad=%0d haddr=%h, want 4/0/40001230",
                     o.nonseq, o.addr_bad, o.haddr);
        end
        checks++;
        if (o.cyc !== model_latency(3, 0, 1'b0) || o.dph_bad) begin
            errors++; $display("FAIL aphase_cycle: pready cycle=%0d dph_bad=%0d, want 6/0", o.cyc, o.dph_bad);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        idle_cycles(1);
        run_xfer(1'b1, 16'h0100, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0, 0, o1);
        run_xfer(1'b0, 16'h0104, 32'h0, 0, 0, 1'b0, 32'h7777_0001, 0, o2);
        model_prdata = 32'h7777_0001;
        checks++;
        if (o1.cyc !== 3 || o1.nonseq !== 1 || o1.haddr !== 32'h4000_0100 || o1.hwrite !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: cycle=%0d nonseq=%0d haddr=%h hwrite=%b, want 3/1/40000100/1",
                     o1.cyc, o1.nonseq, o1.haddr, o1.hwrite);
        end
        checks++;
        if (o2.cyc !== 3 || o2.nonseq !== 1 || o2.haddr !== 32'h4000_0104 || o2.hwrite !== 1'b0
            || o2.prdata !== model_prdata || o2.side_bad) begin
            errors++;
            $display("FAIL b2b_second: cycle=%0d nonseq=%0d haddr=%h prdata=%h side_bad=%0d, want 3/1/40000104/%h/0",
                     o2.cyc, o2.nonseq, o2.haddr, o2.prdata, o2.side_bad, model_prdata);
        end
    endtask

    task automatic test_psel_drop();
        obs_t o;
        bit   bad;
        bad = 0;
        idle_cycles(1);
        run_xfer(1'b0, 16'h0200, 32'h0, 0, 1, 1'b0, 32'h0F0F_1234, 2, o);
        model_prdata = 32'h0F0F_1234;
        checks++;
        if (o.cyc !== model_latency(0, 1, 1'b0) || o.nonseq !== 1 || o.prdata !== model_prdata) begin
            errors++;
            $display("FAIL psel_drop: cycle=%0d nonseq=%0d prdata=%h, want 4/1/%h",
                     o.cyc, o.nonseq, o.prdata, model_prdata);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycles(1);
            if (htrans !== 2'b00 || pready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL psel_drop_idle: bridge active after dropped transfer, want idle");
        end
    endtask

    task automatic test_no_setup();
        bit bad;
        bad = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (htrans !== 2'b00 || pready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL no_setup: access without setup started a transfer, want none");
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0404; hready = 1'b1; hresp = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; hready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (htrans !== 2'b00 || pready !== 1'b0 || haddr !== 32'h4000_0404) begin
            errors++;
            $display("FAIL reset_mid_pre: htrans=%b pready=%b haddr=%h, want 00/0/40000404", htrans, pready, haddr);
        end
        hready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0; hready = 1'b1;
        model_prdata = 32'h0;
        checks++;
        if (htrans !== 2'b00 || pready !== 1'b0 || prdata !== 32'h0 || haddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: htrans=%b pready=%b prdata=%h haddr=%h, want 00/0/0/0",
                     htrans, pready, prdata, haddr);
        end
        run_xfer(1'b0, 16'h0404, 32'h0, 0, 1, 1'b0, 32'hA5A5_0404, 0, o);
        model_prdata = 32'hA5A5_0404;
        checks++;
        if (o.cyc !== 4 || o.prdata !== model_prdata || o.pslverr !== 1'b0 || o.nonseq !== 1) begin
            errors++;
            $display("FAIL reset_mid_after: cycle=%0d prdata=%h pslverr=%b nonseq=%0d, want 4/%h/0/1",
                     o.cyc, o.prdata, o.pslverr, o.nonseq, model_prdata);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          wr, err;
        int          aw, dw;
        logic [15:0] addr;
        logic [31:0] wdata, rdata;
        for (int i = 0; i < 24; i++) begin
            wr    = 1'($urandom_range(0, 1));
            err   = ($urandom_range(0, 3) == 0);
            aw    = $urandom_range(0, 2);
            dw    = $urandom_range(0, 3);
            addr  = 16'($urandom);
            wdata = $urandom;
            rdata = $urandom;
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
            run_xfer(wr, addr, wdata, aw, dw, err, rdata, 0, o);
            if (!wr) model_prdata = err ? 32'h0 : rdata;
            checks++;
            if (o.cyc !== model_latency(aw, dw, err) || o.prdata !== model_prdata || o.pslverr !== err
                || o.nonseq !== aw + 1 || o.haddr !== (BASE | {16'h0, addr}) || o.hwrite !== wr
                || o.addr_bad || o.dph_bad || o.side_bad) begin
                errors++;
                $display("FAIL random[%0d]: cyc=%0d/%0d prdata=%h/%h pslverr=%b/%b nonseq=%0d/%0d haddr=%h/%h bad=%0d%0d%0d",
                         i, o.cyc, model_latency(aw, dw, err), o.prdata, model_prdata, o.pslverr, err,
                         o.nonseq, aw + 1, o.haddr, BASE | {16'h0, addr}, o.addr_bad, o.dph_bad, o.side_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_aphase_hold();
        test_back_to_back();
        test_psel_drop();
        test_no_setup();
        test_reset_mid();
        test_random();
        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_to_ahbl.md
Name: apb_to_ahbl

Overview:
- APB3 completer to AHB-Lite manager bridge. The reverse of the existing AHB-Lite-to-APB bridge.
- Lets an APB-side initiator (debug/peripheral-side agent) issue single 32-bit transfers into the AHB-Lite fabric.
- Each APB transfer becomes exactly one AHB-Lite NONSEQ SINGLE word transfer. The APB access phase is held with pready low until the AHB data phase completes.

Parameters:
- W_PADDR, 16, APB address width.
- W_HADDR, 32, AHB address width; must be >= W_PADDR.
- W_DATA, 32, data width on both sides.
- HADDR_BASE, 32'h0000_0000, base OR-ed into the AHB address. Low W_PADDR bits must be zero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- apbs_psel  in  1  APB select.
- apbs_penable  in  1  APB enable (access phase).
- apbs_pwrite  in  1  APB write.
- apbs_paddr  in  W_PADDR  APB address.
- apbs_pwdata  in  W_DATA  APB write data.
- apbs_pready  out  1  APB ready.
- apbs_prdata  out  W_DATA  APB read data.
- apbs_pslverr  out  1  APB error.
- ahblm_haddr  out  W_HADDR  AHB address = HADDR_BASE | latched paddr.
- ahblm_hwrite  out  1  AHB write.
- ahblm_htrans  out  2  AHB transfer type: 2'b10 (NONSEQ) or 2'b00 (IDLE) only.
- ahblm_hsize  out  3  constant 3'b010.
- ahblm_hburst  out  3  constant 3'b000.
- ahblm_hprot  out  4  constant 4'b0011.
- ahblm_hmastlock  out  1  constant 0.
- ahblm_hwdata  out  W_DATA  AHB write data.
- ahblm_hready  in  1  AHB ready.
- ahblm_hresp  in  1  AHB error response.
- ahblm_hrdata  in  W_DATA  AHB read data.

Behaviour:
- Clock is clk; rst_n is synchronous and active-low. All state updates occur on posedge clk only.
- Reset values:
  - state = S_IDLE; htrans = 2'b00.
  - haddr, hwrite, hwdata, prdata, pslverr all 0; pready = 0.
- States (4):
  - S_IDLE: pready = 0, htrans = IDLE. If psel && !penable, latch paddr, pwrite and pwdata, then go to S_APHASE. Otherwise stay.
  - S_APHASE: htrans = NONSEQ; haddr and hwrite come from the latched values. If hready, go to S_DPHASE. If hready is low, hold all address-phase outputs stable and stay.
  - S_DPHASE: htrans = IDLE; hwdata = latched wdata, stable for the whole phase. If hready:
    - reads: prdata <= (hresp ? 0 : hrdata);
    - writes: prdata is unchanged;
    - err <= hresp;
    - go to S_RESP.
    If hready is low (wait state, or first cycle of a two-cycle error response), stay.
  - S_RESP: pready = 1 and pslverr = err, both combinational from the state; prdata stable. Always go to S_IDLE next cycle.
- pready is asserted only in S_RESP; pslverr is 0 outside S_RESP.
- Latency with a zero-wait AHB slave:
  - setup = cycle 0, pready high in cycle 3, so the APB transfer takes 4 cycles.
  - Each AHB wait state adds one cycle.
- Only one AHB transfer is ever outstanding. The address phase never overlaps a data phase of this bridge.
- The APB initiator's next setup phase (cycle after pready) is sampled in S_IDLE, so back-to-back APB transfers need no bubble.
- psel dropped mid-transfer (protocol violation):
  - the AHB transfer still runs to completion;
  - S_RESP is still visited for one cycle, and the response is discarded;
  - the state then returns to S_IDLE.
- psel && penable seen in S_IDLE without a prior setup phase: ignored, no transfer.
- Reset asserted mid-operation: state goes to S_IDLE and htrans to IDLE at the reset edge; any AHB data phase in flight is abandoned. System reset covers the fabric too.
- hrdata is sampled only when hready is high in S_DPHASE.

Test Plan:
- APB write paddr=16'h0040, pwdata=32'hDEAD_BEEF, HADDR_BASE=32'h4000_0000, zero-wait AHB -> one NONSEQ with haddr=32'h4000_0040, hwrite=1, hsize=3'b010; hwdata=32'hDEAD_BEEF in the data phase; pready high exactly in cycle 3; pslverr=0.
- APB read paddr=16'h0008, slave returns 32'h1234_5678 after 2 wait states -> pready high in cycle 5; prdata=32'h1234_5678; pslverr=0.
- AHB error response (hresp=1/hready=0, then hresp=1/hready=1) on a read -> pslverr=1 and prdata=0 in the pready cycle; htrans stays IDLE through both error cycles.
- hready held low for 3 cycles during S_APHASE -> htrans=NONSEQ and haddr held stable for all 4 cycles; exactly one transfer issued.
- Back-to-back write then read with no APB idle cycle -> two NONSEQ transfers, each a single cycle; second setup accepted the cycle after the first pready.
- rst_n driven low during S_DPHASE -> next cycle state is IDLE, htrans=0, pready=0, prdata=0; a subsequent APB read completes normally.
